// File: rtl/adaptive_test_gen.sv
// adaptive_test_gen
// Adaptive random test-pattern generator. Candidate vectors come from a
// 32-bit Fibonacci LFSR. Each candidate is fault-simulated against the whole
// fault list, one request at a time. A vector is kept when the number of
// newly detected faults reaches an adaptively tracked expectation.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   start            : begin a generation run (only honoured in IDLE/DONE)
//   vec_out          : current candidate vector
//   inj_valid        : one-cycle request: inject fault fault_idx, apply vec_out
//   fault_idx        : 1-based fault index of the request
//   resp_valid       : simulator response strobe (only honoured in WAIT)
//   good_out         : fault-free circuit response
//   faulty_out       : faulty circuit response
//   keep_valid       : one-cycle pulse, vec_out is a kept test
//   busy, done       : run in progress / run finished (sticky)
//   kept_cnt         : number of kept vectors (saturating)
//   total_cnt        : number of generated vectors (saturating)
//   detected_cnt     : number of faults detected by kept vectors (saturating)
module adaptive_test_gen #(
  parameter int unsigned IN_W       = 178,
  parameter int unsigned OUT_W      = 123,
  parameter int unsigned NUM_FAULTS = 5104,
  parameter int unsigned INIT_EXP   = 2,
  parameter int unsigned UT_LIMIT   = 20,
  parameter int unsigned COV_PCT    = 90,
  parameter logic [31:0] SEED       = 32'h1,
  localparam int unsigned FIDX_W    = $clog2(NUM_FAULTS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IN_W-1:0]   vec_out,
  output logic              inj_valid,
  output logic [FIDX_W-1:0] fault_idx,
  input  logic              resp_valid,
  input  logic [OUT_W-1:0]  good_out,
  input  logic [OUT_W-1:0]  faulty_out,
  output logic              keep_valid,
  output logic              busy,
  output logic              done,
  output logic [15:0]       kept_cnt,
  output logic [15:0]       total_cnt,
  output logic [FIDX_W-1:0] detected_cnt
);

  // Bitmaps are sized to the full index range so fault_idx indexes them
  // directly; entry 0 and entries above NUM_FAULTS are never set.
  localparam int unsigned MAP_W      = 1 << FIDX_W;
  localparam int unsigned GCNT_W     = $clog2(IN_W + 1);
  localparam logic [31:0] SEED_EFF   = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam int unsigned COV_TARGET = COV_PCT * NUM_FAULTS;

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_INJECT, S_WAIT, S_EVAL, S_MERGE, S_DONE
  } state_t;

  state_t              state;
  logic [31:0]         lfsr;
  logic [GCNT_W-1:0]   gen_cnt;
  logic [MAP_W-1:0]    detected_at;  // detected by kept vectors this run
  logic [MAP_W-1:0]    detected_ct;  // detected by the current candidate
  logic [FIDX_W-1:0]   new_cnt;
  logic [FIDX_W-1:0]   exp_cnt;
  logic [15:0]         ut_cnt;

  logic                lfsr_fb;
  logic [FIDX_W:0]     exp_sum;
  logic [FIDX_W-1:0]   exp_upd;
  logic                keep;
  logic [FIDX_W:0]     det_sum;
  logic [FIDX_W-1:0]   det_next;
  logic                cov_met_cur;
  logic                cov_met_next;
  logic                ut_hit;
  logic                fault_last;
  logic                mismatch;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next-state helpers: LFSR feedback, expectation update, keep and stop tests
  always_comb begin
    lfsr_fb      = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
    exp_sum      = {1'b0, new_cnt} + {1'b0, exp_cnt};
    if (new_cnt < exp_cnt) begin
      exp_upd = exp_cnt >> 1;
    end else begin
      exp_upd = exp_sum[FIDX_W:1];
    end
    keep         = (new_cnt >= exp_upd) && (new_cnt != '0);
    det_sum      = {1'b0, detected_cnt} + {1'b0, new_cnt};
    if (det_sum[FIDX_W]) begin
      det_next = '1;
    end else begin
      det_next = det_sum[FIDX_W-1:0];
    end
    // Coverage compared as 100*detected >= COV_PCT*NUM_FAULTS, no division
    cov_met_cur  = ((32'(detected_cnt) * 32'd100) >= COV_TARGET);
    cov_met_next = ((32'(det_next) * 32'd100) >= COV_TARGET);
    ut_hit       = (32'(ut_cnt) >= UT_LIMIT);
    fault_last   = (fault_idx == FIDX_W'(NUM_FAULTS));
    mismatch     = (good_out != faulty_out);
  end

  // Main controller FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      lfsr         <= SEED_EFF;
      gen_cnt      <= '0;
      detected_at  <= '0;
      detected_ct  <= '0;
      new_cnt      <= '0;
      exp_cnt      <= FIDX_W'(INIT_EXP);
      ut_cnt       <= 16'd0;
      vec_out      <= '0;
      inj_valid    <= 1'b0;
      fault_idx    <= '0;
      keep_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      kept_cnt     <= 16'd0;
      total_cnt    <= 16'd0;
      detected_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            detected_at  <= '0;
            detected_cnt <= '0;
            kept_cnt     <= 16'd0;
            total_cnt    <= 16'd0;
            ut_cnt       <= 16'd0;
            exp_cnt      <= FIDX_W'(INIT_EXP);
            gen_cnt      <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            state        <= S_GEN;
          end else begin
            state <= state;
          end
        end
        S_GEN: begin
          // LFSR keeps running across candidates and runs; only rst reseeds
          lfsr    <= {lfsr[30:0], lfsr_fb};
          vec_out <= {vec_out[IN_W-2:0], lfsr_fb};
          if (gen_cnt == GCNT_W'(IN_W - 1)) begin
            gen_cnt     <= '0;
            total_cnt   <= sat_inc16(total_cnt);
            ut_cnt      <= sat_inc16(ut_cnt);
            fault_idx   <= FIDX_W'(1);
            new_cnt     <= '0;
            detected_ct <= '0;
            inj_valid   <= 1'b1;
            state       <= S_INJECT;
          end else begin
            gen_cnt <= gen_cnt + GCNT_W'(1);
          end
        end
        S_INJECT: begin
          inj_valid <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (resp_valid) begin
            if (mismatch) begin
              detected_ct[fault_idx] <= 1'b1;
              // Faults already covered by a kept vector are not new
              if (!detected_at[fault_idx]) begin
                new_cnt <= new_cnt + FIDX_W'(1);
              end
            end
            if (fault_last) begin
              state <= S_EVAL;
            end else begin
              fault_idx <= fault_idx + FIDX_W'(1);
              inj_valid <= 1'b1;
              state     <= S_INJECT;
            end
          end else begin
            state <= S_WAIT;
          end
        end
        S_EVAL: begin
          exp_cnt <= exp_upd;
          if (keep) begin
            keep_valid <= 1'b1;
            state      <= S_MERGE;
          end else if (cov_met_cur || ut_hit) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_GEN;
          end
        end
        S_MERGE: begin
          keep_valid   <= 1'b0;
          detected_at  <= detected_at | detected_ct;
          detected_cnt <= det_next;
          kept_cnt     <= sat_inc16(kept_cnt);
          ut_cnt       <= 16'd0;
          if (cov_met_next) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_GEN;
          end
        end
        default: begin
          inj_valid  <= 1'b0;
          keep_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adaptive_test_gen.sv
// Directed testbench for adaptive_test_gen with a small fault-simulator
// responder driven by a per-vector detection mask table.
module tb_adaptive_test_gen;

  localparam int IN_W = 8;
  localparam int OUT_W = 8;
  localparam int NF = 4;
  localparam int FW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [IN_W-1:0]  vec_out;
  logic             inj_valid;
  logic [FW-1:0]    fault_idx;
  logic             resp_valid;
  logic [OUT_W-1:0] good_out;
  logic [OUT_W-1:0] faulty_out;
  logic             keep_valid;
  logic             busy;
  logic             done;
  logic [15:0]      kept_cnt;
  logic [15:0]      total_cnt;
  logic [FW-1:0]    detected_cnt;

  int vectors = 0;
  int miscompares = 0;

  // responder state
  logic             resp_en;
  logic             m_valid;
  logic             a_valid;
  logic [OUT_W-1:0] a_faulty;
  logic             pending;
  logic [FW-1:0]    pidx;
  logic [3:0]       cur_mask;
  logic [3:0]       mask_tab [0:7];
  int               vcount = 0;
  int               vbase = 0;

  // observation logs
  logic [IN_W-1:0]  vec_log  [0:63];
  logic [IN_W-1:0]  keep_log [0:63];
  int               vec_n = 0;
  int               keep_n = 0;

  logic [31:0]      lfsr_m;

  always #5 clk = ~clk;

  assign resp_valid = resp_en ? a_valid : m_valid;
  assign good_out   = 8'h5A;
  assign faulty_out = resp_en ? a_faulty : (m_valid ? 8'hA5 : 8'h5A);

  adaptive_test_gen #(
    .IN_W(IN_W), .OUT_W(OUT_W), .NUM_FAULTS(NF), .INIT_EXP(2),
    .UT_LIMIT(3), .COV_PCT(50), .SEED(32'h1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .vec_out(vec_out),
    .inj_valid(inj_valid), .fault_idx(fault_idx), .resp_valid(resp_valid),
    .good_out(good_out), .faulty_out(faulty_out), .keep_valid(keep_valid),
    .busy(busy), .done(done), .kept_cnt(kept_cnt), .total_cnt(total_cnt),
    .detected_cnt(detected_cnt)
  );

  // Simulator model: answer each request one cycle later; also log vectors
  always @(negedge clk) begin
    a_valid  = 1'b0;
    a_faulty = 8'h5A;
    if (!resp_en) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        a_valid  = 1'b1;
        a_faulty = cur_mask[pidx - 3'd1] ? 8'hA5 : 8'h5A;
        pending  = 1'b0;
      end
      if (inj_valid) begin
        if (fault_idx == 3'd1) begin
          vcount   = vcount + 1;
          cur_mask = mask_tab[(vcount - vbase - 1) & 7];
        end
        pending = 1'b1;
        pidx    = fault_idx;
      end
    end
    if (inj_valid && fault_idx == 3'd1) begin
      vec_log[vec_n & 63] = vec_out;
      vec_n = vec_n + 1;
    end
    if (keep_valid) begin
      keep_log[keep_n & 63] = vec_out;
      keep_n = keep_n + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // reference LFSR: taps 32,22,2,1, feedback bit is the generated bit
  task automatic model_vec(output logic [IN_W-1:0] v);
    logic fb;
    v = '0;
    for (int i = 0; i < IN_W; i++) begin
      fb = lfsr_m[31] ^ lfsr_m[21] ^ lfsr_m[1] ^ lfsr_m[0];
      lfsr_m = {lfsr_m[30:0], fb};
      v = {v[IN_W-2:0], fb};
    end
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    while (!done && c < 400) begin
      @(negedge clk);
      c++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, expected 1", name, done, c);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; resp_en = 1'b0; m_valid = 1'b0;
    lfsr_m = 32'h1;
    tick(3);
    rst = 1'b0;
    tick(2);
    vectors += 9;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    if (inj_valid !== 1'b0) begin miscompares++; $display("FAIL reset_inj: got %b want 0", inj_valid); end
    if (keep_valid !== 1'b0) begin miscompares++; $display("FAIL reset_keep: got %b want 0", keep_valid); end
    if (vec_out !== 8'h00) begin miscompares++; $display("FAIL reset_vec: got %h want 00", vec_out); end
    if (fault_idx !== 3'd0) begin miscompares++; $display("FAIL reset_fidx: got %0d want 0", fault_idx); end
    if (kept_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_kept: got %0d want 0", kept_cnt); end
    if (total_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_total: got %0d want 0", total_cnt); end
    if (detected_cnt !== 3'd0) begin miscompares++; $display("FAIL reset_det: got %0d want 0", detected_cnt); end
  endtask

  task automatic test_idle_resp();
    @(negedge clk) m_valid = 1'b1;
    @(negedge clk) m_valid = 1'b0;
    tick(2);
    vectors += 4;
    if (detected_cnt !== 3'd0) begin miscompares++; $display("FAIL idle_resp_det: got %0d want 0", detected_cnt); end
    if (dut.new_cnt !== 3'd0) begin miscompares++; $display("FAIL idle_resp_new: got %0d want 0", dut.new_cnt); end
    if (dut.detected_ct !== 8'h00) begin miscompares++; $display("FAIL idle_resp_map: got %h want 00", dut.detected_ct); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_resp_busy: got %b want 0", busy); end
  endtask

  // faults 1 and 3 detected by the first vector: kept, coverage 50% reached
  task automatic test_keep_first();
    int kb, vb;
    logic [IN_W-1:0] mv;
    mask_tab[0] = 4'b0101;
    vbase = vcount; kb = keep_n; vb = vec_n;
    resp_en = 1'b1;
    pulse_start();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL keep_first_busy: got %b want 1", busy); end
    wait_done("keep_first");
    model_vec(mv);
    vectors += 8;
    if (keep_n - kb != 1) begin miscompares++; $display("FAIL keep_first_pulses: got %0d want 1", keep_n - kb); end
    if (keep_log[kb & 63] !== 8'hB6) begin miscompares++; $display("FAIL keep_first_vec: got %h want b6", keep_log[kb & 63]); end
    if (vec_log[vb & 63] !== mv) begin miscompares++; $display("FAIL keep_first_model: got %h want %h", vec_log[vb & 63], mv); end
    if (kept_cnt !== 16'd1) begin miscompares++; $display("FAIL keep_first_kept: got %0d want 1", kept_cnt); end
    if (total_cnt !== 16'd1) begin miscompares++; $display("FAIL keep_first_total: got %0d want 1", total_cnt); end
    if (detected_cnt !== 3'd2) begin miscompares++; $display("FAIL keep_first_det: got %0d want 2", detected_cnt); end
    if (dut.exp_cnt !== 3'd2) begin miscompares++; $display("FAIL keep_first_exp: got %0d want 2", dut.exp_cnt); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL keep_first_idle: got %b want 0", busy); end
    tick(3);
    vectors++;
    if (done !== 1'b1) begin miscompares++; $display("FAIL done_sticky: got %b want 1", done); end
  endtask

  // nothing ever detected: stops on useless-test limit, exp 2->1->0->0
  task automatic test_unkept();
    int kb, vb;
    logic [IN_W-1:0] mv;
    for (int i = 0; i < 8; i++) mask_tab[i] = 4'b0000;
    vbase = vcount; kb = keep_n; vb = vec_n;
    pulse_start();
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL unkept_done_clear: got %b want 0", done); end
    wait_done("unkept");
    vectors += 7;
    if (total_cnt !== 16'd3) begin miscompares++; $display("FAIL unkept_total: got %0d want 3", total_cnt); end
    if (kept_cnt !== 16'd0) begin miscompares++; $display("FAIL unkept_kept: got %0d want 0", kept_cnt); end
    if (detected_cnt !== 3'd0) begin miscompares++; $display("FAIL unkept_det: got %0d want 0", detected_cnt); end
    if (keep_n != kb) begin miscompares++; $display("FAIL unkept_pulses: got %0d want 0", keep_n - kb); end
    if (vec_n - vb != 3) begin miscompares++; $display("FAIL unkept_vecs: got %0d want 3", vec_n - vb); end
    if (dut.exp_cnt !== 3'd0) begin miscompares++; $display("FAIL unkept_exp: got %0d want 0", dut.exp_cnt); end
    if (vec_log[vb & 63] !== 8'hDB) begin miscompares++; $display("FAIL unkept_vec0_hand: got %h want db", vec_log[vb & 63]); end
    for (int i = 0; i < 3; i++) begin
      model_vec(mv);
      vectors++;
      if (vec_log[(vb + i) & 63] !== mv) begin
        miscompares++;
        $display("FAIL unkept_vec%0d: got %h want %h", i, vec_log[(vb + i) & 63], mv);
      end
    end
  endtask

  // fault 1 re-detected by the second vector must not count as new
  task automatic test_redetect();
    int kb;
    logic [IN_W-1:0] v0, v1, v2;
    mask_tab[0] = 4'b0001; mask_tab[1] = 4'b0001; mask_tab[2] = 4'b0011;
    vbase = vcount; kb = keep_n;
    pulse_start();
    wait_done("redetect");
    model_vec(v0); model_vec(v1); model_vec(v2);
    vectors += 6;
    if (kept_cnt !== 16'd2) begin miscompares++; $display("FAIL redetect_kept: got %0d want 2", kept_cnt); end
    if (total_cnt !== 16'd3) begin miscompares++; $display("FAIL redetect_total: got %0d want 3", total_cnt); end
    if (detected_cnt !== 3'd2) begin miscompares++; $display("FAIL redetect_det: got %0d want 2", detected_cnt); end
    if (keep_n - kb != 2) begin miscompares++; $display("FAIL redetect_pulses: got %0d want 2", keep_n - kb); end
    if (keep_log[kb & 63] !== v0) begin miscompares++; $display("FAIL redetect_keep0: got %h want %h", keep_log[kb & 63], v0); end
    if (keep_log[(kb + 1) & 63] !== v2) begin miscompares++; $display("FAIL redetect_keep1: got %h want %h", keep_log[(kb + 1) & 63], v2); end
  endtask

  // reset in WAIT, late response, then restart from the seed
  task automatic test_reset_wait();
    int c = 0;
    int vb;
    logic [IN_W-1:0] mv;
    resp_en = 1'b0;
    for (int i = 0; i < 8; i++) mask_tab[i] = 4'b0000;
    pulse_start();
    while (!inj_valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    vectors++;
    if (inj_valid !== 1'b1) begin miscompares++; $display("FAIL rstwait_inj_timeout: got %b want 1", inj_valid); end
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(negedge clk) m_valid = 1'b1;
    @(negedge clk) m_valid = 1'b0;
    tick(1);
    vectors += 8;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rstwait_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL rstwait_done: got %b want 0", done); end
    if (inj_valid !== 1'b0) begin miscompares++; $display("FAIL rstwait_inj: got %b want 0", inj_valid); end
    if (vec_out !== 8'h00) begin miscompares++; $display("FAIL rstwait_vec: got %h want 00", vec_out); end
    if (fault_idx !== 3'd0) begin miscompares++; $display("FAIL rstwait_fidx: got %0d want 0", fault_idx); end
    if (total_cnt !== 16'd0) begin miscompares++; $display("FAIL rstwait_total: got %0d want 0", total_cnt); end
    if (detected_cnt !== 3'd0) begin miscompares++; $display("FAIL rstwait_det: got %0d want 0", detected_cnt); end
    if (dut.new_cnt !== 3'd0) begin miscompares++; $display("FAIL rstwait_new: got %0d want 0", dut.new_cnt); end
    lfsr_m = 32'h1;
    vbase = vcount; vb = vec_n;
    pulse_start();
    // response and a second start during GEN must both be ignored
    @(negedge clk) begin m_valid = 1'b1; start = 1'b1; end
    @(negedge clk) begin m_valid = 1'b0; start = 1'b0; end
    resp_en = 1'b1;
    wait_done("rstwait_run");
    vectors += 4;
    if (vec_log[vb & 63] !== 8'hB6) begin miscompares++; $display("FAIL rstwait_seed_vec: got %h want b6", vec_log[vb & 63]); end
    if (total_cnt !== 16'd3) begin miscompares++; $display("FAIL rstwait_run_total: got %0d want 3", total_cnt); end
    if (kept_cnt !== 16'd0) begin miscompares++; $display("FAIL rstwait_run_kept: got %0d want 0", kept_cnt); end
    if (vec_n - vb != 3) begin miscompares++; $display("FAIL rstwait_run_vecs: got %0d want 3", vec_n - vb); end
    for (int i = 0; i < 3; i++) begin
      model_vec(mv);
      vectors++;
      if (vec_log[(vb + i) & 63] !== mv) begin
        miscompares++;
        $display("FAIL rstwait_vec%0d: got %h want %h", i, vec_log[(vb + i) & 63], mv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_resp();
    test_keep_first();
    test_unkept();
    test_redetect();
    test_reset_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adaptive_test_gen.md
ADAPTIVE_TEST_GEN -- requirements
Module: adaptive_test_gen

Interface
REQ-001 SHALL have parameter IN_W, default 178, test-vector width.
REQ-002 SHALL have parameter OUT_W, default 123, circuit output width.
REQ-003 SHALL have parameter NUM_FAULTS, default 5104, fault-list length; FIDX_W = clog2(NUM_FAULTS+1).
REQ-004 SHALL have parameters INIT_EXP (2), UT_LIMIT (20), COV_PCT (90), SEED (32'h1) for initial expected-new-fault count, useless-test limit, target coverage percent and LFSR seed.
REQ-005 SHALL have one clock; reset is synchronous and active-high: clk in 1 system clock; rst in 1 synchronous active-high reset.
REQ-006 start in 1, pulse that begins a generation run from IDLE.
REQ-007 vec_out out IN_W, current candidate vector to the fault simulator.
REQ-008 inj_valid out 1, one-cycle request to inject fault fault_idx and apply vec_out; fault_idx out FIDX_W, 1-based.
REQ-009 resp_valid in 1, good_out in OUT_W, faulty_out in OUT_W: simulator response for the outstanding request.
REQ-010 keep_valid out 1, one-cycle pulse, vec_out is a kept test.
REQ-011 busy out 1; done out 1 (sticky until start/rst); kept_cnt, total_cnt out 16; detected_cnt out FIDX_W.

Function
REQ-012 SHALL be FSM: IDLE, GEN, INJECT, WAIT, EVAL, MERGE, DONE.
REQ-013 IDLE: on start clear detected_at bitmap, detected_cnt, kept_cnt, total_cnt, ut_cnt; exp := INIT_EXP; -> GEN.
REQ-014 GEN: 32-bit Fibonacci LFSR (taps 32,22,2,1; SEED 0 replaced by 1) shifts once per cycle for IN_W cycles, output bit shifted into vec_out LSB; then total_cnt++, ut_cnt++, fault_idx := 1, new_cnt := 0, clear detected_ct bitmap; -> INJECT.
REQ-015 INJECT: assert inj_valid one cycle; -> WAIT. At most one request outstanding.
REQ-016 WAIT: hold until resp_valid; resp_valid outside WAIT SHALL be ignored.
REQ-017 On resp_valid with good_out != faulty_out: set detected_ct[fault_idx]; if detected_at[fault_idx]==0, new_cnt++.
REQ-018 After response: if fault_idx == NUM_FAULTS -> EVAL, else fault_idx++ -> INJECT.
REQ-019 EVAL (one cycle): exp := (new_cnt < exp) ? exp>>1 : (new_cnt+exp)>>1; keep SHALL be new_cnt >= updated exp AND new_cnt > 0.
REQ-020 Keep: -> MERGE; detected_at |= detected_ct; detected_cnt += new_cnt; kept_cnt++; ut_cnt := 0; keep_valid pulses with vec_out stable.
REQ-021 Termination checked after EVAL/MERGE: 100*detected_cnt >= COV_PCT*NUM_FAULTS (integer, no division) or ut_cnt >= UT_LIMIT -> DONE; else -> GEN.
REQ-022 LFSR state SHALL persist across candidates within a run and across runs (not reseeded by start).
REQ-023 Counters SHALL saturate at all-ones.
REQ-024 DONE: done=1, busy=0; start -> same as IDLE start.
REQ-025 start while busy SHALL be ignored.
REQ-026 exp reaching 0 SHALL stay 0; keep then needs only new_cnt > 0.

Reset
REQ-027 rst SHALL, at any state including mid-WAIT, force IDLE, clear all counters, bitmaps, outputs (inj_valid, keep_valid, busy, done = 0, vec_out = 0, fault_idx = 0), exp := INIT_EXP, LFSR := SEED.
REQ-028 Responses arriving after reset SHALL be ignored.

Verification
REQ-029 IN_W=8, NUM_FAULTS=4, model flags faults 1,3 differ on first vector -> new_cnt=2, exp=2, keep_valid once, detected_cnt=2, kept_cnt=1.
REQ-030 Model never flags any fault, UT_LIMIT=3 -> total_cnt=3, kept_cnt=0, done after third EVAL; exp sequence 2,1,0,0.
REQ-031 Same fault re-detected by a later vector -> new_cnt excludes it, detected_cnt unchanged.
REQ-032 COV_PCT=50, NUM_FAULTS=4, 2 faults detected by first kept vector -> done immediately after MERGE.
REQ-033 rst asserted during WAIT, then resp_valid -> no counter change, busy=0, next start generates vector from SEED.
REQ-034 resp_valid pulsed in GEN/IDLE -> no bitmap or counter change.
